// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared constants and FSM encoding for the AES decryption round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NUM_ROUNDS_DEF - default AES round count (AES-128)
//   RK_IDX_W       - width of the round-key store index
//   state_t        - sequencer FSM state encoding
package aes_dec_pkg;

  localparam int NUM_ROUNDS_DEF = 10;
  localparam int RK_IDX_W       = 4;

  // IDLE: waiting for ciphertext.
  // P1/P2/P3: the three phases of one inverse round on the external round datapath.
  // DONE: plaintext presented on the output handshake.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/aes_dec_perf_cnt.sv
// aes_dec_perf_cnt: block-completion and busy-cycle performance counters.
// Latency: counters update one edge after the qualifying cycle.
// Backpressure: none; counts only, both counters wrap modulo 2^32.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   sys_en     - global advance enable; busy cycles are counted only while high
//   busy       - controller is working on (or presenting) a block
//   out_hs     - output handshake completed this cycle (already qualified by sys_en)
//   blk_cnt    - number of output handshakes
//   cyc_cnt    - number of enabled cycles spent busy
module aes_dec_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_en,
  input  logic        busy,
  input  logic        out_hs,
  output logic [31:0] blk_cnt,
  output logic [31:0] cyc_cnt
);

  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    if (out_hs) begin
      blk_cnt_d = blk_cnt_q + 32'd1;
    end
    if (sys_en && busy) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
  assign cyc_cnt = cyc_cnt_q;

endmodule

// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: sequences an external single-round AES inverse-cipher datapath over all rounds of a block.
// Latency: m_valid rises 3*NUM_ROUNDS enabled edges after the accept edge (three phases per round).
// Backpressure: one block in flight; s_ready low while busy, plaintext held in DONE until m_ready.
//
// Optional feature: define AES_DEC_CTRL_PERF_EN to build the blk_cnt/cyc_cnt counters;
// otherwise both ports are tied to zero.
//
// Ports:
//   clk, rst_n            - clock (rising edge) and asynchronous active-low reset
//   sys_en                - global advance enable; low freezes all state
//   key_valid             - round-key store fully expanded; gates new accepts only
//   s_valid/s_ready/s_data - ciphertext input handshake
//   m_valid/m_ready/m_data - plaintext output handshake
//   rk_idx / rk_data      - round-key store address and its combinational read data
//   rnd_state_in          - state fed to the round datapath (always the working state cur)
//   rnd_key               - round key fed to the round datapath (pass-through of rk_data)
//   rnd_sel_imc           - InvMixColumns select; low only for the final round
//   rnd_en                - advance enable for the round output register
//   rnd_state_out         - registered round result
//   busy                  - high from accept until the output handshake
//   blk_cnt, cyc_cnt      - performance counters
module aes_dec_ctrl
  import aes_dec_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sys_en,
  input  logic                key_valid,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [127:0]        s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [127:0]        m_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_data,
  output logic [127:0]        rnd_state_in,
  output logic [127:0]        rnd_key,
  output logic                rnd_sel_imc,
  output logic                rnd_en,
  input  logic [127:0]        rnd_state_out,
  output logic                busy,
  output logic [31:0]         blk_cnt,
  output logic [31:0]         cyc_cnt
);

  // Index of the whitening key applied at accept, and of the first inverse round.
  localparam logic [RK_IDX_W-1:0] IDX_LAST  = RK_IDX_W'(NUM_ROUNDS);
  localparam logic [RK_IDX_W-1:0] IDX_FIRST = RK_IDX_W'(NUM_ROUNDS - 1);

  state_t              state_q, state_d;
  logic [127:0]        cur_q, cur_d;
  logic [RK_IDX_W-1:0] ri_q, ri_d;
  logic                m_valid_q, m_valid_d;
  logic [127:0]        m_data_q, m_data_d;

  logic in_hs;

  assign s_ready = (state_q == ST_IDLE) && key_valid && sys_en;
  assign in_hs   = s_valid && s_ready;

  // Next-state logic. Every update is qualified by sys_en so that a low
  // enable freezes the whole controller, including a pending output.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ri_d      = ri_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (sys_en) begin
      case (state_q)
        ST_IDLE: begin
          if (in_hs) begin
            // rk_idx points at the last key in IDLE, so this is the initial AddRoundKey.
            cur_d   = s_data ^ rk_data;
            ri_d    = IDX_FIRST;
            state_d = ST_P1;
          end
        end
        ST_P1: begin
          // Round datapath captures InvSubBytes(cur) internally this cycle.
          state_d = ST_P2;
        end
        ST_P2: begin
          // rnd_en is high here; the round output register captures at this edge.
          state_d = ST_P3;
        end
        ST_P3: begin
          cur_d = rnd_state_out;
          if (ri_q == '0) begin
            m_valid_d = 1'b1;
            m_data_d  = rnd_state_out;
            state_d   = ST_DONE;
          end else begin
            ri_d    = ri_q - RK_IDX_W'(1);
            state_d = ST_P1;
          end
        end
        ST_DONE: begin
          // s_ready is low in DONE, so no accept can coincide with this handshake.
          if (m_ready) begin
            m_valid_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      ri_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      ri_q      <= ri_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign rk_idx       = (state_q == ST_IDLE) ? IDX_LAST : ri_q;
  assign rnd_state_in = cur_q;
  assign rnd_key      = rk_data;
  // Final round (ri==0) skips InvMixColumns.
  assign rnd_sel_imc  = (ri_q != '0);
  // Gated by sys_en so a frozen cycle in P2 never advances the round register.
  assign rnd_en       = (state_q == ST_P2) && sys_en;
  assign busy         = (state_q != ST_IDLE);
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;

`ifdef AES_DEC_CTRL_PERF_EN
  logic out_hs;
  assign out_hs = m_valid_q && m_ready && sys_en;

  aes_dec_perf_cnt u_perf_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .sys_en  (sys_en),
    .busy    (busy),
    .out_hs  (out_hs),
    .blk_cnt (blk_cnt),
    .cyc_cnt (cyc_cnt)
  );
`else
  assign blk_cnt = '0;
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: self-checking bench for aes_dec_ctrl with a behavioural AES round datapath and key store.
// Latency: n/a (bench).
// Backpressure: exercises m_ready stalls, sys_en freezes and key_valid gating.
module tb_aes_dec_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sys_en = 1'b0;
  logic         key_valid = 1'b0;
  logic         s_valid = 1'b0;
  logic [127:0] s_data = '0;
  logic         m_ready = 1'b0;

  logic         s_ready, m_valid, rnd_sel_imc, rnd_en, busy;
  logic [127:0] m_data, rk_data, rnd_state_in, rnd_key;
  logic [127:0] rnd_out;
  logic [3:0]   rk_idx;
  logic [31:0]  blk_cnt, cyc_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox  [0:255];
  logic [7:0]   isbox [0:255];
  logic [127:0] rk_mem [0:10];

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_dec_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sys_en        (sys_en),
    .key_valid     (key_valid),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .rk_idx        (rk_idx),
    .rk_data       (rk_data),
    .rnd_state_in  (rnd_state_in),
    .rnd_key       (rnd_key),
    .rnd_sel_imc   (rnd_sel_imc),
    .rnd_en        (rnd_en),
    .rnd_state_out (rnd_out),
    .busy          (busy),
    .blk_cnt       (blk_cnt),
    .cyc_cnt       (cyc_cnt)
  );

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  // Direct inverse cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic imc);
    logic [127:0] t, u;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(c*4+r) -: 8] = isbox[getb(s, ((c - r + 4) % 4) * 4 + r)];
    t = t ^ k;
    if (!imc) return t;
    u = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = getb(t, 4*c); a1 = getb(t, 4*c+1); a2 = getb(t, 4*c+2); a3 = getb(t, 4*c+3);
      u[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      u[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      u[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      u[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return u;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk_mem[NR];
    for (int r = NR - 1; r >= 1; r--) s = inv_round(s, rk_mem[r], 1'b1);
    return inv_round(s, rk_mem[0], 1'b0);
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b, r1, r2, r3, r4, sv, rc;
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [127:0] key;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      r1 = {b[6:0], b[7]}; r2 = {r1[6:0], r1[7]}; r3 = {r2[6:0], r2[7]}; r4 = {r3[6:0], r3[7]};
      sv = b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
      sbox[x] = sv;
      isbox[sv] = 8'(x);
    end
    key = KEY;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Key store read port and the external round datapath.
  assign rk_data = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd_out <= '0;
    else if (rnd_en) rnd_out <= inv_round(rnd_state_in, rnd_key, rnd_sel_imc);
  end

  // ---------------- behavioural model ----------------
  // A block is tracked by the number of enabled edges since its accept (k):
  // each round takes three, the working state changes every third, output at 3*NR.
  bit           in_blk = 0;
  int           k = 0;
  logic         mval_m = 1'b0;
  logic [127:0] cur_m = '0;
  logic [127:0] exp_q [$];
  logic [31:0]  blk_m = '0;
  logic [31:0]  cyc_m = '0;

  always @(posedge clk or negedge rst_n) begin
    int idx;
    if (!rst_n) begin
      in_blk = 0; k = 0; mval_m = 1'b0; cur_m = '0; exp_q.delete(); blk_m = '0; cyc_m = '0;
    end else if (sys_en) begin
      if (in_blk) cyc_m = cyc_m + 32'd1;
      if (!in_blk) begin
        if (s_valid && key_valid) begin
          in_blk = 1; k = 0;
          cur_m = s_data ^ rk_mem[NR];
          exp_q.push_back(aes_dec(s_data));
        end
      end else if (k < 3*NR) begin
        k++;
        if (k % 3 == 0) begin
          idx = NR - k/3;
          cur_m = inv_round(cur_m, rk_mem[idx], idx != 0);
        end
        if (k == 3*NR) mval_m = 1'b1;
      end else if (m_ready) begin
        blk_m = blk_m + 32'd1;
        in_blk = 0; mval_m = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_srdy, e_ren, e_imc;
    logic [3:0] e_idx;
    e_srdy = !in_blk && key_valid && sys_en;
    e_ren  = in_blk && (k < 3*NR) && (k % 3 == 1) && sys_en;
    e_imc  = in_blk && (k < 3*NR) && (k/3 < NR - 1);
    chk1("s_ready", s_ready, e_srdy);
    chk1("busy", busy, logic'(in_blk));
    chk1("m_valid", m_valid, mval_m);
    chk1("rnd_en", rnd_en, e_ren);
    chk1("rnd_sel_imc", rnd_sel_imc, e_imc);
    chk128("rnd_state_in", rnd_state_in, cur_m);
    if (!in_blk || k < 3*NR) begin
      e_idx = in_blk ? 4'(NR - 1 - k/3) : 4'(NR);
      chk32("rk_idx", 32'(rk_idx), 32'(e_idx));
      chk128("rnd_key", rnd_key, rk_mem[e_idx]);
    end
    if (mval_m) begin
      if (exp_q.size() == 0) chk1("exp_queue_nonempty", 1'b0, 1'b1);
      else chk128("m_data", m_data, exp_q[0]);
    end
`ifdef AES_DEC_CTRL_PERF_EN
    chk32("blk_cnt", blk_cnt, blk_m);
    chk32("cyc_cnt", cyc_cnt, cyc_m);
`else
    chk32("blk_cnt", blk_cnt, 32'd0);
    chk32("cyc_cnt", cyc_cnt, 32'd0);
`endif
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer d until accepted; returns just after the accept edge.
  task automatic send(input logic [127:0] d);
    bit ok;
    ok = 0;
    s_data = d; s_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk1("accept_timeout", logic'(ok), 1'b1);
  endtask

  // Counts edges from the accept edge until m_valid; optionally alternates sys_en every edge.
  task automatic wait_mvalid(input bit toggle, output int lat);
    lat = 0;
    while (!m_valid && lat < 200) begin
      if (toggle) sys_en = ~sys_en;
      @(posedge clk); #1;
      lat++;
    end
    if (toggle) sys_en = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk1("idle_timeout", busy, 1'b0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [127:0] d, e;

    build_tables();
    // Pin the reference model with published constants.
    chk32("sbox_00", 32'(sbox[8'h00]), 32'h63);
    chk32("sbox_53", 32'(sbox[8'h53]), 32'hed);
    chk32("isbox_00", 32'(isbox[8'h00]), 32'h52);
    chk128("rk10", rk_mem[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk128("model_fips", aes_dec(CT), PT);

    // Reset state.
    #1 rst_n = 1'b0;
    key_valid = 1'b1; sys_en = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rnd_en", rnd_en, 1'b0);
    chk128("rst_m_data", m_data, '0);
    chk128("rst_cur", rnd_state_in, '0);
    chk32("rst_rk_idx", 32'(rk_idx), 32'd10);
    chk32("rst_blk", blk_cnt, 32'd0);
    chk32("rst_cyc", cyc_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 vector, then two back-to-back blocks for the counters.
    send(CT);
    wait_mvalid(1'b0, lat);
    chk32("lat_fips", 32'(lat), 32'd30);
    chk128("pt_fips", m_data, PT);
    send(rnd128());
    send(rnd128());
    wait_idle();
    tick();
`ifdef AES_DEC_CTRL_PERF_EN
    chk32("blk_cnt_3", blk_cnt, 32'd3);
    chk32("cyc_cnt_93", cyc_cnt, 32'd93);
`else
    chk32("blk_cnt_off", blk_cnt, 32'd0);
    chk32("cyc_cnt_off", cyc_cnt, 32'd0);
`endif

    // Output stall: plaintext held, no accept, single handshake on release.
    m_ready = 1'b0;
    d = rnd128();
    e = aes_dec(d);
    send(d);
    wait_mvalid(1'b0, lat);
    s_valid = 1'b1; s_data = rnd128();
    repeat (10) begin
      tick();
      chk1("stall_m_valid", m_valid, 1'b1);
      chk128("stall_m_data", m_data, e);
      chk1("stall_s_ready", s_ready, 1'b0);
    end
    m_ready = 1'b1;
    tick();
    chk1("release_m_valid", m_valid, 1'b0);
    chk1("release_no_accept", busy, 1'b0);
    s_valid = 1'b0;
    tick();
    chk1("release_idle", busy, 1'b0);

    // sys_en alternating during a block doubles the latency.
    send(CT);
    wait_mvalid(1'b1, lat);
    chk32("lat_toggle", 32'(lat), 32'd60);
    chk128("pt_toggle", m_data, PT);
    tick();

    // Reset in P2 of round 5 discards the block.
    send(rnd128());
    repeat (13) tick();
    chk1("p2_round5_rnd_en", rnd_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("midrst_m_valid", m_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_rnd_en", rnd_en, 1'b0);
    chk1("midrst_imc", rnd_sel_imc, 1'b0);
    chk128("midrst_m_data", m_data, '0);
    chk128("midrst_cur", rnd_state_in, '0);
    chk32("midrst_blk", blk_cnt, 32'd0);
    chk32("midrst_cyc", cyc_cnt, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    send(CT);
    wait_mvalid(1'b0, lat);
    chk32("lat_postrst", 32'(lat), 32'd30);
    chk128("pt_postrst", m_data, PT);
    tick();

    // key_valid gates accepts; a drop mid-block is ignored.
    key_valid = 1'b0;
    d = rnd128();
    s_data = d; s_valid = 1'b1;
    repeat (3) begin
      tick();
      chk1("nokey_s_ready", s_ready, 1'b0);
      chk1("nokey_busy", busy, 1'b0);
    end
    key_valid = 1'b1;
    #1;
    chk1("key_s_ready", s_ready, 1'b1);
    tick();
    chk1("key_accept", busy, 1'b1);
    s_valid = 1'b0;
    repeat (5) tick();
    key_valid = 1'b0;
    wait_mvalid(1'b0, lat);
    chk128("pt_keydrop", m_data, aes_dec(d));
    key_valid = 1'b1;
    tick();

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 2500; i++) begin
      sys_en    = ($urandom % 5) != 0;
      key_valid = ($urandom % 8) != 0;
      s_valid   = ($urandom % 2) != 0;
      s_data    = rnd128();
      m_ready   = ($urandom % 3) != 0;
      tick();
    end
    sys_en = 1'b1; key_valid = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    wait_idle();
    tick();
    chk32("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
